// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
// sort_pkg : shared word/frame types and size defaults for the sorter datapath
// Rev 1.0
// ============================================================================
package sort_pkg;

  localparam int SORT_N     = 6;
  localparam int SORT_WIDTH = 8;
  localparam int SORT_CNT_W = $clog2(SORT_N + 1);

  typedef logic [SORT_WIDTH-1:0] word_t;
  typedef word_t                 frame_t [SORT_N];
  typedef logic [SORT_CNT_W-1:0] cnt_t;

endpackage
`default_nettype wire

// File: rtl/frame_bank.sv
`default_nettype none
// ============================================================================
// frame_bank : one frame of storage with write index, close/pad logic and
//              a full flag that holds the frame until it is read out.
// Rev 1.0
// ============================================================================
module frame_bank
  import sort_pkg::*;
#(
  parameter int               N     = SORT_N,
  parameter int               WIDTH = SORT_WIDTH,
  parameter logic [WIDTH-1:0] PAD   = {WIDTH{1'b1}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_wr,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_last,
  input  logic                         i_rd_done,
  output logic                         o_full,
  output logic [WIDTH-1:0]             o_data [N],
  output logic [$clog2(N+1)-1:0]       o_count
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0]    r_wr_idx;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic [WIDTH-1:0] r_data [N];
  logic             w_closing;

  // The Nth word closes the frame whether or not it carries in_last.
  assign w_closing = i_last | (r_wr_idx == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_idx <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      for (int i = 0; i < N; i++) r_data[i] <= '0;
    end else begin
      if (i_rd_done) r_full <= 1'b0;
      if (i_wr) begin
        for (int i = 0; i < N; i++) begin
          if (CW'(i) == r_wr_idx)
            r_data[i] <= i_data;
          else if (w_closing && (CW'(i) > r_wr_idx))
            r_data[i] <= PAD;
        end
        if (w_closing) begin
          r_count  <= r_wr_idx + 1'b1;
          r_wr_idx <= '0;
          r_full   <= 1'b1;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
    end
  end

  assign o_full  = r_full;
  assign o_count = r_count;
  always_comb begin
    for (int i = 0; i < N; i++) o_data[i] = r_data[i];
  end

endmodule
`default_nettype wire

// File: rtl/sort_frame_loader.sv
`default_nettype none
// ============================================================================
// sort_frame_loader : assembles a serial word stream into padded N-word frames
//                     held stable for the sorter. SORT_LOADER_PINGPONG_EN
//                     selects two banks (fill one while the other is held).
// Rev 1.0
// ============================================================================
module sort_frame_loader
  import sort_pkg::*;
#(
  parameter int               N     = SORT_N,
  parameter int               WIDTH = SORT_WIDTH,
  parameter logic [WIDTH-1:0] PAD   = {WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       frame_data [N],
  output logic [$clog2(N+1)-1:0] frame_count,
  output logic                   frame_valid,
  input  logic                   frame_ready
);

  localparam int CW = $clog2(N + 1);
`ifdef SORT_LOADER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  logic [NB-1:0]    w_full;
  logic [NB-1:0]    w_wr;
  logic [NB-1:0]    w_rd;
  logic [WIDTH-1:0] w_data  [NB][N];
  logic [CW-1:0]    w_count [NB];
  logic             w_wsel;
  logic             w_rsel;
  logic             w_accept;
  logic             w_take;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    assign w_wr[b] = w_accept & (w_wsel == 1'(b));
    assign w_rd[b] = w_take   & (w_rsel == 1'(b));
    frame_bank #(
      .N     (N),
      .WIDTH (WIDTH),
      .PAD   (PAD)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .i_wr      (w_wr[b]),
      .i_data    (in_data),
      .i_last    (in_last),
      .i_rd_done (w_rd[b]),
      .o_full    (w_full[b]),
      .o_data    (w_data[b]),
      .o_count   (w_count[b])
    );
  end

`ifdef SORT_LOADER_PINGPONG_EN
  logic r_wr_ptr;
  logic r_rd_ptr;

  // r_wr_ptr follows the newest written bank; once it is full, writes move to
  // the other bank, which is also the oldest frame when both are full.
  assign w_wsel = w_full[r_wr_ptr] ? ~r_wr_ptr : r_wr_ptr;
  assign w_rsel = r_rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (!w_full[w_wsel]) r_wr_ptr <= w_wsel;
      if (w_take)          r_rd_ptr <= ~r_rd_ptr;
    end
  end
`else
  assign w_wsel = 1'b0;
  assign w_rsel = 1'b0;
`endif

  assign in_ready    = ~rst & ~w_full[w_wsel];
  assign w_accept    = in_valid & in_ready;
  assign frame_valid = w_full[w_rsel];
  assign w_take      = frame_valid & frame_ready;
  assign frame_count = w_count[w_rsel];

  always_comb begin
    for (int i = 0; i < N; i++) frame_data[i] = w_data[w_rsel][i];
  end

endmodule
`default_nettype wire

// File: tb/tb_sort_frame_loader.sv
`default_nettype none
// ============================================================================
// tb_sort_frame_loader : directed and random stimulus against a frame-queue
//                        reference model of sort_frame_loader.
// Rev 1.0
// ============================================================================
module tb_sort_frame_loader;

  localparam int N  = 6;
  localparam int W  = 8;
  localparam int CW = $clog2(N + 1);
`ifdef SORT_LOADER_PINGPONG_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          in_ready;
  logic [W-1:0]  frame_data [N];
  logic [CW-1:0] frame_count;
  logic          frame_valid;
  logic          frame_ready;

  always #5 clk = ~clk;

  sort_frame_loader #(.N(N), .WIDTH(W), .PAD({W{1'b1}})) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .frame_data  (frame_data),
    .frame_count (frame_count),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready)
  );

  typedef struct packed {
    logic [N-1:0][W-1:0] d;
    logic [7:0]          cnt;
  } frame_s;

  frame_s       q[$];
  logic [W-1:0] cur[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: a queue of closed frames (capacity = number of banks) plus the
  // words of the frame currently being gathered.
  task automatic model_step();
    bit     acc;
    bit     tk;
    frame_s f;
    acc = in_valid && (q.size() < CAP);
    tk  = frame_ready && (q.size() > 0);
    if (tk) void'(q.pop_front());
    if (acc) begin
      cur.push_back(in_data);
      if (in_last || cur.size() == N) begin
        for (int i = 0; i < N; i++) f.d[i] = (i < cur.size()) ? cur[i] : {W{1'b1}};
        f.cnt = 8'(cur.size());
        q.push_back(f);
        cur.delete();
      end
    end
  endtask

  task automatic check_outputs();
    chk("in_ready", 32'(in_ready), 32'(q.size() < CAP));
    chk("frame_valid", 32'(frame_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      for (int i = 0; i < N; i++)
        chk($sformatf("frame_data[%0d]", i), 32'(frame_data[i]), 32'(q[0].d[i]));
      chk("frame_count", 32'(frame_count), 32'(q[0].cnt));
    end
  endtask

  task automatic step(input bit v, input logic [W-1:0] d, input bit l, input bit r);
    in_valid    = v;
    in_data     = d;
    in_last     = l;
    frame_ready = r;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    chk("rst frame_valid", 32'(frame_valid), 32'd0);
    chk("rst frame_count", 32'(frame_count), 32'd0);
    for (int i = 0; i < N; i++)
      chk($sformatf("rst frame_data[%0d]", i), 32'(frame_data[i]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    cur.delete();
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [W-1:0] w6 [6];
    rst         = 1'b1;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    frame_ready = 1'b0;
    do_reset();

    // Full frame without in_last, then hold with in_valid toggling.
    w6 = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2};
    for (int i = 0; i < 6; i++) step(1'b1, w6[i], 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'(i % 2), 8'hA0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);

    // Short frame padded.
    do_reset();
    step(1'b1, 8'd4, 1'b0, 1'b0);
    step(1'b1, 8'd8, 1'b1, 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 8'd0, 1'b0, 1'b1);

    // in_last on the Nth word, then a one-word frame starting at slot 0.
    for (int i = 0; i < 6; i++) step(1'b1, 8'h20 + 8'(i), 1'(i == 5), 1'b0);
    step(1'b0, 8'd0, 1'b0, 1'b1);
    step(1'b1, 8'h11, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 8'd0, 1'b0, 1'b1);

    // Reset mid-fill, then a clean frame.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h77, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 8'd0, 1'b0, 1'b1);

    // Continuous input with the consumer always ready.
    for (int i = 0; i < 24; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b0, 1'b1);

    // Continuous input with the consumer stalled, then drain.
    for (int i = 0; i < 14; i++) step(1'b1, 8'h80 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 8'd0, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 9) < 7), 8'($urandom),
           1'($urandom_range(0, 9) < 2), 1'($urandom_range(0, 1)));

    // Reset mid-hold discards the held frame.
    for (int i = 0; i < 6; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 8'd0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sort_frame_loader.md
# sort_frame_loader

Upstream feeder for the combinational N-input sorter. Accepts a serial valid/ready word stream, assembles N-word frames in registers, and presents each frame as a stable parallel vector, with a frame-level handshake, until the sorter-side consumer accepts it. Short frames (terminated early by `in_last`) are padded so the sorter always sees N defined inputs.

## Interface
Parameters:
- `N`, 6: words per frame; sorter input count.
- `WIDTH`, 8: bits per word.
- `PAD`, `{WIDTH{1'b1}}`: fill value for unused slots of a short frame.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  WIDTH  upstream word.
- `in_last`  in  1  word is the final word of its frame; qualified by `in_valid`.
- `in_ready`  out  1  loader can accept a word this cycle.
- `frame_data[N]`  out  WIDTH each  assembled frame; slot 0 is the first word received.
- `frame_count`  out  $clog2(N+1)  number of real words in `frame_data`, 1..N.
- `frame_valid`  out  1  `frame_data` and `frame_count` are valid and held stable.
- `frame_ready`  in  1  consumer accepts the frame this cycle.

## Operation
- Accept: `in_valid && in_ready`. Word goes to slot `wr_idx`; `wr_idx` increments.
- Frame closes on an accepted word with `in_last=1`, or on the accepted word at `wr_idx==N-1` (implicit last). `in_last` on the Nth word is the same event; no empty frame results.
- On close, the slots at index ≥ count are loaded with `PAD`; `frame_count` = words written; `wr_idx` resets to 0.
- FSM, one bank (default):
  - FILL: `in_ready=1`, `frame_valid=0`. Close → HOLD.
  - HOLD: `in_ready=0`, `frame_valid=1`; data frozen. `frame_ready` → FILL.
- `frame_ready` while `frame_valid=0` is ignored.
- `frame_data` is registered; no combinational path from `in_*` to `frame_*`.
- `in_ready` is a decode of registered state only and does not depend on `in_valid`.

## Timing
- Reset (asynchronous): `frame_valid=0`, `frame_count=0`, all `frame_data` = 0, `wr_idx=0`, state FILL. `in_ready=0` while `rst` is high and 1 in the first cycle after release.
- Latency: closing word accepted at edge k → `frame_valid=1` after edge k. Frame accepted at edge m → `frame_valid=0` after edge m (single bank).
- Full-frame throughput (single bank): N accept cycles plus one HOLD cycle minimum.
- Reset mid-fill or mid-hold discards the partial or held frame. No frame is emitted after reset until a new close.
- `frame_valid`, once high, stays high with unchanged data until accepted.

## Configuration
- `SORT_LOADER_PINGPONG_EN` defined: two banks. One bank fills while the other is held.
  - `in_ready=0` only when both banks hold closed frames.
  - Frames are emitted in arrival order.
  - If the other bank is closed when `frame_ready` is accepted, `frame_valid` stays 1 and the next frame appears after that same edge (back-to-back).
  - A close and an accept in the same cycle are both honoured.
- Not defined: single bank, FSM exactly as in Operation.

## Structure
- Shared package `sort_pkg`: `WIDTH`/`N` defaults, `word_t` (logic [WIDTH-1:0]), `frame_t` (array of N `word_t`), `cnt_t` (`$clog2(N+1)` bits). The sorter uses the same package.
- One natural sub-module: `frame_bank` holds one frame's storage, write index, close/pad logic and its full flag. It is instantiated once, or twice under `SORT_LOADER_PINGPONG_EN`, with a 1-bit read/write pointer pair in the top.

## Test plan
- Reset, then words 5,3,9,1,7,2, no `in_last`, `frame_ready=0` → `frame_valid=1` the cycle after the 6th accept; `frame_data`=5,3,9,1,7,2; `frame_count`=6; `in_ready=0` (single bank).
- Words 4,8 with `in_last` on 8 → `frame_data`=4,8,FF,FF,FF,FF; `frame_count`=2.
- `in_last` on the 6th word → exactly one frame, count 6; the next word starts a new frame at slot 0.
- Held frame, `frame_ready` low for 10 cycles while `in_valid` toggles → `frame_data` unchanged; no words accepted (single bank).
- `rst` pulsed after 3 words → all outputs at reset values; the next 6 words form a clean frame with no stale data.
- With `SORT_LOADER_PINGPONG_EN`: continuous input, `frame_ready=1` → `frame_valid` stays high across back-to-back frames, in order. With `frame_ready=0`, `in_ready` drops after the 12th word.
